// File: rtl/vvprojectvv_vga_timing_if.sv
// Raster output bundle of the VGA timing generator.
// Master drives counts and decodes; slave is the renderer side.
interface vvprojectvv_vga_timing_if;
    logic        pixTick;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hSync;
    logic        vSync;
    logic        bright;
    logic        frameTick;
    logic [15:0] frameCount;

    modport master (
        output pixTick, hCount, vCount,
        output hSync, vSync, bright,
        output frameTick, frameCount
    );

    modport slave (
        input pixTick, hCount, vCount,
        input hSync, vSync, bright,
        input frameTick, frameCount
    );
endinterface

// File: rtl/vvprojectvv_vga_timing.sv
// VGA 640x480@60 timing generator: pixel divider, raster sweep,
// registered sync/visible decodes and a frame tick/counter.
module vvprojectvv_vga_timing #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
) (
    input  logic clk,
    input  logic reset_n,
    vvprojectvv_vga_timing_if.master vga
);
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_TOP = DW'(CLK_DIV - 1);
    localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
    localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS    = 10'(H_SYNC);
    localparam logic [9:0] VS    = 10'(V_SYNC);
    localparam logic [9:0] HVS   = 10'(H_VIS_START);
    localparam logic [9:0] HVE   = 10'(H_VIS_END);
    localparam logic [9:0] VVS   = 10'(V_VIS_START);
    localparam logic [9:0] VVE   = 10'(V_VIS_END);

    logic [DW-1:0] div_q;
    logic [9:0]    h_q, v_q;
    logic [9:0]    h_nxt, v_nxt;
    logic [15:0]   frm_q;
    logic          pix_q, tick_q;
    logic          hs_q, vs_q, br_q;
    logic          adv, wrap;

    // Next raster position; decodes are taken from it so they line up
    // with the counts they describe.
    always_comb begin
        adv   = (div_q == DIV_TOP);
        h_nxt = h_q;
        v_nxt = v_q;
        if (adv) begin
            if (h_q == HT_M1) begin
                h_nxt = '0;
                v_nxt = (v_q == VT_M1) ? '0 : v_q + 10'd1;
            end else begin
                h_nxt = h_q + 10'd1;
            end
        end
        wrap = adv && (h_q == HT_M1) && (v_q == VT_M1);
    end

    // Divider, raster counters, decodes and frame bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            frm_q  <= '0;
            pix_q  <= 1'b0;
            tick_q <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            br_q   <= 1'b0;
        end else begin
            div_q  <= adv ? '0 : div_q + DW'(1);
            pix_q  <= adv;
            h_q    <= h_nxt;
            v_q    <= v_nxt;
            tick_q <= wrap;
            if (wrap)
                frm_q <= frm_q + 16'd1;
            hs_q   <= (h_nxt >= HS);
            vs_q   <= (v_nxt >= VS);
            br_q   <= (h_nxt >= HVS) && (h_nxt < HVE) &&
                      (v_nxt >= VVS) && (v_nxt < VVE);
        end
    end

    assign vga.pixTick    = pix_q;
    assign vga.hCount     = h_q;
    assign vga.vCount     = v_q;
    assign vga.hSync      = hs_q;
    assign vga.vSync      = vs_q;
    assign vga.bright     = br_q;
    assign vga.frameTick  = tick_q;
    assign vga.frameCount = frm_q;
endmodule

// File: tb/tb_vvprojectvv_vga_timing.sv
// Directed bench for the VGA timing generator; raster positions are
// deposited into the counters to reach edges without full frames.
module tb_vvprojectvv_vga_timing;
    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_fail;

    logic [9:0]  dep_h;
    logic [9:0]  dep_v;
    logic [15:0] dep_f;

    vvprojectvv_vga_timing_if vga ();

    vvprojectvv_vga_timing dut (
        .clk     (clk),
        .reset_n (reset_n),
        .vga     (vga)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_pix"}, 32'(vga.pixTick), 0);
        check({tag, "_h"},   32'(vga.hCount), 0);
        check({tag, "_v"},   32'(vga.vCount), 0);
        check({tag, "_hs"},  32'(vga.hSync), 0);
        check({tag, "_vs"},  32'(vga.vSync), 0);
        check({tag, "_br"},  32'(vga.bright), 0);
        check({tag, "_ft"},  32'(vga.frameTick), 0);
        check({tag, "_fc"},  32'(vga.frameCount), 0);
    endtask

    // Wait for the next negedge at which pixTick is high.
    task automatic wait_adv(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (vga.pixTick) seen = 1'b1;
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    // Deposit a raster position; called just after a pixel advance.
    task automatic deposit(input logic [9:0] h, input logic [9:0] v);
        dep_h = h;
        dep_v = v;
        force dut.h_q = dep_h;
        force dut.v_q = dep_v;
        #1;
        release dut.h_q;
        release dut.v_q;
    endtask

    task automatic pos(input string tag, input logic [9:0] h,
                       input logic [9:0] v, input logic hs,
                       input logic vs, input logic br);
        check({tag, "_h"},  32'(vga.hCount), 32'(h));
        check({tag, "_v"},  32'(vga.vCount), 32'(v));
        check({tag, "_hs"}, 32'(vga.hSync), 32'(hs));
        check({tag, "_vs"}, 32'(vga.vSync), 32'(vs));
        check({tag, "_br"}, 32'(vga.bright), 32'(br));
    endtask

    task automatic release_check(input string tag);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check({tag, "_pix_early"}, 32'(vga.pixTick), 0);
            check({tag, "_h_early"}, 32'(vga.hCount), 0);
        end
        @(negedge clk);
        check({tag, "_pix1"}, 32'(vga.pixTick), 1);
        check({tag, "_h1"}, 32'(vga.hCount), 1);
        check({tag, "_v1"}, 32'(vga.vCount), 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check({tag, "_pix_gap"}, 32'(vga.pixTick), 0);
        end
        @(negedge clk);
        check({tag, "_pix2"}, 32'(vga.pixTick), 1);
        check({tag, "_h2"}, 32'(vga.hCount), 2);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        dep_h   = '0;
        dep_v   = '0;
        dep_f   = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        all_zero("rst");
        release_check("rel");

        // line wrap
        deposit(10'd798, 10'd10);
        wait_adv("lw0");
        pos("lw799", 10'd799, 10'd10, 1'b1, 1'b1, 1'b0);
        wait_adv("lw1");
        pos("lw0", 10'd0, 10'd11, 1'b0, 1'b1, 1'b0);

        // hSync rising edge
        deposit(10'd94, 10'd40);
        wait_adv("hs0");
        pos("hs95", 10'd95, 10'd40, 1'b0, 1'b1, 1'b0);
        wait_adv("hs1");
        pos("hs96", 10'd96, 10'd40, 1'b1, 1'b1, 1'b0);

        // bright start at (144,35)
        deposit(10'd142, 10'd35);
        wait_adv("bs0");
        pos("br143", 10'd143, 10'd35, 1'b1, 1'b1, 1'b0);
        wait_adv("bs1");
        pos("br144", 10'd144, 10'd35, 1'b1, 1'b1, 1'b1);

        // bright end at hCount 784
        deposit(10'd782, 10'd100);
        wait_adv("be0");
        pos("br783", 10'd783, 10'd100, 1'b1, 1'b1, 1'b1);
        wait_adv("be1");
        pos("br784", 10'd784, 10'd100, 1'b1, 1'b1, 1'b0);

        // bright vertical bounds
        deposit(10'd200, 10'd34);
        wait_adv("bv0");
        pos("brv34", 10'd201, 10'd34, 1'b1, 1'b1, 1'b0);
        deposit(10'd200, 10'd514);
        wait_adv("bv1");
        pos("brv514", 10'd201, 10'd514, 1'b1, 1'b1, 1'b1);
        deposit(10'd200, 10'd515);
        wait_adv("bv2");
        pos("brv515", 10'd201, 10'd515, 1'b1, 1'b1, 1'b0);

        // vSync window
        deposit(10'd799, 10'd0);
        wait_adv("vs0");
        pos("vs1", 10'd0, 10'd1, 1'b0, 1'b0, 1'b0);
        wait_adv("vs1a");
        deposit(10'd799, 10'd1);
        wait_adv("vs2");
        pos("vs2", 10'd0, 10'd2, 1'b0, 1'b1, 1'b0);
        deposit(10'd799, 10'd523);
        wait_adv("vs3");
        pos("vs524", 10'd0, 10'd524, 1'b0, 1'b1, 1'b0);

        // frame wrap
        deposit(10'd798, 10'd524);
        wait_adv("fw0");
        pos("fw799", 10'd799, 10'd524, 1'b1, 1'b1, 1'b0);
        check("fw_pre_ft", 32'(vga.frameTick), 0);
        check("fw_pre_fc", 32'(vga.frameCount), 0);
        wait_adv("fw1");
        pos("fw00", 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        check("fw_ft", 32'(vga.frameTick), 1);
        check("fw_fc", 32'(vga.frameCount), 1);
        @(negedge clk);
        check("fw_ft_off", 32'(vga.frameTick), 0);
        check("fw_fc_hold", 32'(vga.frameCount), 1);

        // frame counter rollover
        wait_adv("ro0");
        dep_f = 16'hFFFF;
        force dut.frm_q = dep_f;
        deposit(10'd799, 10'd524);
        release dut.frm_q;
        check("ro_pre_fc", 32'(vga.frameCount), 65535);
        wait_adv("ro1");
        pos("ro00", 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        check("ro_ft", 32'(vga.frameTick), 1);
        check("ro_fc", 32'(vga.frameCount), 0);

        // mid-frame reset
        deposit(10'd399, 10'd200);
        wait_adv("mr0");
        pos("mr400", 10'd400, 10'd200, 1'b1, 1'b1, 1'b1);
        dep_f = 16'd7;
        force dut.frm_q = dep_f;
        #1 release dut.frm_q;
        #1 reset_n = 1'b0;
        #1 all_zero("mrst");
        repeat (2) @(negedge clk);
        all_zero("mrst_hold");
        release_check("mrel");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
